// File: rtl/riscv32_mem_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch and load/store ports.
// One transaction at a time: IDLE -> ISSUE -> WAIT(MEM_LAT) -> IDLE, all outputs registered.
`timescale 1ns/1ps
module riscv32_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [3:0] LP_LAT  = MEM_LAT[3:0];
  localparam logic [3:0] LP_SMAX = STARVE_MAX[3:0];

  logic [1:0]        r_state;
  logic [3:0]        r_lat_cnt;
  logic [3:0]        r_starve;
  logic              r_win_d, r_win_we;
  logic              r_if_gnt, r_if_rvalid, r_d_gnt, r_d_rvalid;
  logic              r_mem_en, r_mem_we, r_busy;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;

  logic w_go, w_pick_d;
  // Data wins a tie unless fetch has been passed over STARVE_MAX times in a row.
  assign w_go     = (if_req | d_req) & ~halted;
  assign w_pick_d = d_req & (~if_req | (r_starve != LP_SMAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= '0;
      r_starve    <= '0;
      r_win_d     <= 1'b0;
      r_win_we    <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_wdata <= '0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!if_req) r_starve <= '0;
          if (w_go) begin
            r_state  <= S_ISSUE;
            r_busy   <= 1'b1;
            r_mem_en <= 1'b1;
            r_win_d  <= w_pick_d;
            r_win_we <= w_pick_d & d_we;
            if (w_pick_d) begin
              r_d_gnt     <= 1'b1;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              r_mem_be    <= d_we ? d_be : 4'hF;
              // A data win with fetch waiting implies r_starve < STARVE_MAX.
              if (if_req) r_starve <= r_starve + 4'd1;
            end else begin
              r_if_gnt   <= 1'b1;
              r_mem_addr <= if_addr;
              r_mem_be   <= 4'hF;
              r_starve   <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_state   <= S_WAIT;
          r_lat_cnt <= LP_LAT;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (r_win_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= r_win_we ? '0 : mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign busy      = r_busy;
endmodule

// File: tb/tb_riscv32_mem_arbiter.sv
// Bench for riscv32_mem_arbiter: cycle table on a MEM_LAT=1 instance, directed corner sequences,
// and random traffic on a MEM_LAT=3 / STARVE_MAX=2 instance checked against a transaction-level model.
`timescale 1ns/1ps
module tb_riscv32_mem_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int SM_B  = 2;

  logic clk = 1'b0;
  logic rst_n, halted, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  int cyc = 0;
  int checks = 0, failures = 0;

  logic a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;
  logic b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_be(a_mem_be), .mem_rdata(a_mem_rdata), .busy(a_busy));

  riscv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(SM_B)) u_b (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .busy(b_busy));

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0)  return 32'h00a00093;
    if (a == 32'h40) return 32'h0000_1234;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory models: read data is valid only in cycle (mem_en cycle + latency), junk otherwise.
  int a_due = -1, b_due = -1;
  logic [31:0] a_pend = '0, b_pend = '0;
  always @(negedge clk) begin
    a_mem_rdata = (cyc == a_due) ? memval(a_pend) : $urandom;
    if (a_mem_en) begin a_due = cyc + LAT_A; a_pend = a_mem_addr; end
    b_mem_rdata = (cyc == b_due) ? memval(b_pend) : $urandom;
    if (b_mem_en) begin b_due = cyc + LAT_B; b_pend = b_mem_addr; end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // inp = {if_req, d_req, d_we, halted}; exp = {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, busy}
  typedef struct packed {
    logic [3:0]  inp;
    logic [6:0]  exp;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [22];

  function automatic vec_t v(input logic [3:0] i, input logic [6:0] e, input logic [31:0] r);
    return {i, e, r};
  endfunction

  logic        found, found2;
  logic [5:0]  order;
  int          n, cnt, t0, lat;
  logic [6:0]  ev, av;
  logic [31:0] mexp_addr;
  logic [3:0]  mexp_be;

  // random-run model state
  int          g_cyc, r_cyc, starve, k;
  logic        g_d, g_we, saw_ig, saw_dg, eg, inb;
  logic [31:0] g_addr, r_data;

  initial begin
    rst_n = 1'b0; halted = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

    tbl[0]  = v(4'b1000, 7'b0000000, 32'h0);
    tbl[1]  = v(4'b0000, 7'b1010001, 32'h0);
    tbl[2]  = v(4'b0000, 7'b0000001, 32'h0);
    tbl[3]  = v(4'b1100, 7'b0000100, 32'h00a00093);
    tbl[4]  = v(4'b1000, 7'b0110001, 32'h0);
    tbl[5]  = v(4'b1000, 7'b0000001, 32'h0);
    tbl[6]  = v(4'b1000, 7'b0000010, 32'h1234);
    tbl[7]  = v(4'b0110, 7'b1010001, 32'h0);
    tbl[8]  = v(4'b0110, 7'b0000001, 32'h0);
    tbl[9]  = v(4'b0110, 7'b0000100, 32'h00a00093);
    tbl[10] = v(4'b0000, 7'b0111001, 32'h0);
    tbl[11] = v(4'b0000, 7'b0000001, 32'h0);
    tbl[12] = v(4'b1000, 7'b0000010, 32'h0);
    tbl[13] = v(4'b0101, 7'b1010001, 32'h0);
    tbl[14] = v(4'b0101, 7'b0000001, 32'h0);
    tbl[15] = v(4'b0101, 7'b0000100, 32'h00a00093);
    tbl[16] = v(4'b0101, 7'b0000000, 32'h0);
    tbl[17] = v(4'b0100, 7'b0000000, 32'h0);
    tbl[18] = v(4'b0000, 7'b0110001, 32'h0);
    tbl[19] = v(4'b0000, 7'b0000001, 32'h0);
    tbl[20] = v(4'b0000, 7'b0000010, 32'h1234);
    tbl[21] = v(4'b0000, 7'b0000000, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", 64'(|{a_if_gnt, a_if_rvalid, a_if_rdata, a_d_gnt, a_d_rvalid, a_d_rdata,
        a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_be, a_busy}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Cycle table: fetch, tie (data first), store, halt during a fetch.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      {if_req, d_req, d_we, halted} = tbl[i].inp;
      if_addr = 32'h0;
      d_addr  = d_we ? 32'h10 : 32'h40;
      d_wdata = 32'hDEADBEEF;
      d_be    = 4'b0011;
      @(negedge clk);
      ev = tbl[i].exp;
      av = {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_if_rvalid, a_d_rvalid, a_busy};
      chk($sformatf("tbl%0d_ctl", i), 64'(av), 64'(ev));
      if (ev[4]) begin
        mexp_addr = ev[6] ? 32'h0 : (ev[3] ? 32'h10 : 32'h40);
        mexp_be   = ev[3] ? 4'b0011 : 4'hF;
        chk($sformatf("tbl%0d_mem", i), 64'({a_mem_addr, a_mem_be}), 64'({mexp_addr, mexp_be}));
        if (ev[3]) chk($sformatf("tbl%0d_wdata", i), 64'(a_mem_wdata), 64'(32'hDEADBEEF));
      end
      if (ev[2]) chk($sformatf("tbl%0d_if_rdata", i), 64'(a_if_rdata), 64'(tbl[i].rd));
      if (ev[1]) chk($sformatf("tbl%0d_d_rdata", i), 64'(a_d_rdata), 64'(tbl[i].rd));
    end

    // Starvation limit: both held, STARVE_MAX=4 -> D,D,D,D,F,D.
    @(posedge clk); #1;
    if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
    n = 0; order = '0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (a_if_gnt || a_d_gnt) begin order[5-n] = a_d_gnt; n++; end
    end
    chk("starve_order", 64'(order), 64'(6'b111101));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) @(posedge clk);

    // Reset in WAIT on the MEM_LAT=3 instance.
    #1;
    if_addr = 32'h44; if_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin @(negedge clk); found = b_if_gnt; end
    chk("rst_wait_gnt", 64'(found), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    #2;
    chk("rst_wait_busy", 64'(b_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero", 64'(|{b_if_gnt, b_if_rvalid, b_if_rdata, b_d_gnt, b_d_rvalid, b_d_rdata,
        b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_be, b_busy}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(b_if_rvalid) + int'(b_d_rvalid); end
    chk("rst_no_rvalid", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    found = 1'b0; t0 = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (b_d_gnt) begin found = 1'b1; t0 = cyc; end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    found2 = 1'b0; lat = -1;
    for (int c = 0; c < 12 && !found2; c++) begin
      @(negedge clk);
      if (b_d_rvalid) begin found2 = 1'b1; lat = cyc - t0; end
    end
    chk("post_rst_lat", 64'(lat), 64'(LAT_B + 1));
    chk("post_rst_data", 64'(b_d_rdata), 64'(32'h1234));

    // Random traffic on the MEM_LAT=3 instance against a transaction-level model.
    g_cyc = -100; r_cyc = -100; starve = 0; g_d = 1'b0; g_we = 1'b0; g_addr = '0; r_data = '0;
    saw_ig = 1'b0; saw_dg = 1'b0;
    for (int it = 0; it < 600; it++) begin
      @(posedge clk); #1;
      if (saw_ig) if_req = 1'b0;
      if (saw_dg) d_req = 1'b0;
      if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = 32'($urandom_range(255)) << 2;
      end else if (if_req && $urandom_range(15) == 0) if_req = 1'b0;
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1));
        d_addr = 32'($urandom_range(255)) << 2; d_wdata = $urandom; d_be = 4'($urandom_range(15));
      end else if (d_req && $urandom_range(15) == 0) d_req = 1'b0;
      halted = ($urandom_range(7) == 0);
      @(negedge clk);
      k   = cyc;
      eg  = (k == g_cyc);
      inb = (k >= g_cyc) && (k <= g_cyc + LAT_B);
      ev  = {eg & ~g_d, eg & g_d, eg, eg & g_d & g_we, (k == r_cyc) & ~g_d, (k == r_cyc) & g_d, inb};
      av  = {b_if_gnt, b_d_gnt, b_mem_en, b_mem_we, b_if_rvalid, b_d_rvalid, b_busy};
      chk("rnd_ctl", 64'(av), 64'(ev));
      if (eg) chk("rnd_mem_addr", 64'(b_mem_addr), 64'(g_addr));
      if (k == r_cyc) chk("rnd_rdata", 64'(g_d ? b_d_rdata : b_if_rdata), 64'(r_data));
      saw_ig = b_if_gnt; saw_dg = b_d_gnt;
      if (!inb) begin
        if (!if_req) starve = 0;
        if (!halted && (if_req || d_req)) begin
          g_d    = d_req && !(if_req && starve == SM_B);
          g_we   = g_d && d_we;
          g_addr = g_d ? d_addr : if_addr;
          g_cyc  = k + 1;
          r_cyc  = k + LAT_B + 2;
          r_data = g_we ? 32'h0 : memval(g_addr);
          if (!g_d) starve = 0;
          else if (if_req && starve < SM_B) starve++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
